// File: rtl/debug_stepper_pkg.sv
// debug_stepper_pkg
//   Shared definitions for the debug stepper: the stepper state encoding and
//   the default debounce length used on the board (100000 clocks).
package debug_stepper_pkg;

  typedef enum logic [1:0] {
    DBG_FREE    = 2'd0,
    DBG_IDLE    = 2'd1,
    DBG_STEP_HI = 2'd2,
    DBG_STEP_LO = 2'd3
  } dbg_state_e;

  localparam int DB_CYCLES_DEF = 100000;

endpackage

// File: rtl/debug_stepper_debouncer.sv
// debug_stepper_debouncer
//   Two-flop synchronizer followed by a debounce counter for one raw board
//   input. The debounced level only follows the synchronized input once it
//   has differed for DB_CYCLES consecutive clocks; any bounce restarts the
//   count. rise/fall are one-cycle pulses aligned with the level change.
// Ports:
//   clk   in   main clock
//   rst   in   synchronous active-high reset
//   raw   in   asynchronous raw input
//   level out  debounced level
//   rise  out  one-cycle pulse on debounced 0->1
//   fall  out  one-cycle pulse on debounced 1->0
module debug_stepper_debouncer
  import debug_stepper_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (sync2_q != level_q) begin
        // Count reaches DB_CYCLES-1 on the DB_CYCLES-th differing clock.
        if (cnt_q == CW'(DB_CYCLES - 1)) begin
          level_q <= sync2_q;
          rise_q  <= sync2_q;
          fall_q  <= ~sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/debug_stepper.sv
// debug_stepper
//   Generates the controller's debug_en / debug_step pair from the board debug
//   switch and step/burst buttons, with a PC breakpoint that forces a halt.
//   Each debug_step high cycle is exactly one CPU cycle; strobes are always
//   separated by at least one low cycle.
//
//   state   | meaning
//   FREE    | CPU free-running, debug_en=0
//   IDLE    | CPU suspended, waiting for a step/burst event
//   STEP_HI | strobe high for one clock, step_count increments
//   STEP_LO | strobe low gap; continue burst, halt on breakpoint, or leave
//
// Ports:
//   clk, rst            main clock, synchronous active-high reset
//   sw_debug            raw debug-mode switch
//   btn_step, btn_burst raw step / burst buttons
//   burst_len           steps per burst, sampled on the accepted burst event
//   bp_en, bp_addr, pc  breakpoint enable/address and current IF-stage PC
//   debug_en            suspend CPU unless stepping
//   debug_step          step strobe
//   halted              sticky breakpoint-hit flag, cleared by switch release
//   step_count          steps issued since reset (wrapping)
module debug_stepper
  import debug_stepper_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_debug,
  input  logic             btn_step,
  input  logic             btn_burst,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             debug_en,
  output logic             debug_step,
  output logic             halted,
  output logic [15:0]      step_count
);

  logic sw_db;
  logic sw_fall;
  logic step_ev;
  logic burst_ev;
  logic unused_sw_rise;
  logic unused_step_level;
  logic unused_step_fall;
  logic unused_burst_level;
  logic unused_burst_fall;

  debug_stepper_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_sw (
    .clk   (clk),
    .rst   (rst),
    .raw   (sw_debug),
    .level (sw_db),
    .rise  (unused_sw_rise),
    .fall  (sw_fall)
  );

  debug_stepper_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_step),
    .level (unused_step_level),
    .rise  (step_ev),
    .fall  (unused_step_fall)
  );

  debug_stepper_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_burst (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_burst),
    .level (unused_burst_level),
    .rise  (burst_ev),
    .fall  (unused_burst_fall)
  );

  dbg_state_e       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             halted_q, halted_d;
  logic [15:0]      step_cnt_q, step_cnt_d;
  logic             debug_en_q;
  logic             debug_step_q;

  logic hit;
  logic eff;

  assign hit = bp_en && (pc == bp_addr);
  assign eff = sw_db | halted_q;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    halted_d   = halted_q;
    step_cnt_d = step_cnt_q;
    case (state_q)
      DBG_FREE: begin
        if (hit) begin
          halted_d = 1'b1;
          state_d  = DBG_IDLE;
        end else if (eff) begin
          state_d = DBG_IDLE;
        end
      end
      DBG_IDLE: begin
        // A hit here is ignored: the PC cannot move while suspended.
        if (!eff) begin
          state_d = DBG_FREE;
        end else if (step_ev) begin
          rem_d   = CNT_W'(1);
          state_d = DBG_STEP_HI;
        end else if (burst_ev && (burst_len != '0)) begin
          rem_d   = burst_len;
          state_d = DBG_STEP_HI;
        end
      end
      DBG_STEP_HI: begin
        step_cnt_d = step_cnt_q + 16'd1;
        state_d    = DBG_STEP_LO;
      end
      DBG_STEP_LO: begin
        if (!eff) begin
          rem_d   = '0;
          state_d = DBG_FREE;
        end else if (hit) begin
          halted_d = 1'b1;
          rem_d    = '0;
          state_d  = DBG_IDLE;
        end else if (rem_q > CNT_W'(1)) begin
          rem_d   = rem_q - CNT_W'(1);
          state_d = DBG_STEP_HI;
        end else begin
          rem_d   = '0;
          state_d = DBG_IDLE;
        end
      end
      default: state_d = DBG_FREE;
    endcase
    // Switch release dominates a breakpoint hit in the same cycle.
    if (sw_fall) halted_d = 1'b0;
  end

  // Outputs are registered decodes of the next state so they line up with
  // the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DBG_FREE;
      rem_q        <= '0;
      halted_q     <= 1'b0;
      step_cnt_q   <= '0;
      debug_en_q   <= 1'b0;
      debug_step_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      halted_q     <= halted_d;
      step_cnt_q   <= step_cnt_d;
      debug_en_q   <= (state_d != DBG_FREE);
      debug_step_q <= (state_d == DBG_STEP_HI);
    end
  end

  assign debug_en   = debug_en_q;
  assign debug_step = debug_step_q;
  assign halted     = halted_q;
  assign step_count = step_cnt_q;

endmodule

// File: tb/tb_debug_stepper.sv
module tb_debug_stepper;

  localparam int DB = 4;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          sw_debug;
  logic          btn_step;
  logic          btn_burst;
  logic [CW-1:0] burst_len;
  logic          bp_en;
  logic [31:0]   bp_addr;
  logic [31:0]   pc;
  logic          debug_en;
  logic          debug_step;
  logic          halted;
  logic [15:0]   step_count;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  debug_stepper #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_debug   (sw_debug),
    .btn_step   (btn_step),
    .btn_burst  (btn_burst),
    .burst_len  (burst_len),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .debug_en   (debug_en),
    .debug_step (debug_step),
    .halted     (halted),
    .step_count (step_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Debounce: a level flips once the last DB synchronized samples all
  // disagree with it. Stepper: en / strobe / gap flags plus "strobes still
  // owed" after the one currently issued.
  logic        m_s1[3], m_s2[3], m_lvl[3], m_rise[3], m_fall[3];
  logic        m_win[3][DB];
  logic        m_en, m_str, m_gap, m_halt;
  int          m_left;
  logic [15:0] m_steps;
  logic [15:0] pre_off = 16'h0;
  logic        mvalid = 1'b0;

  always @(posedge clk) begin
    logic hit, eff, n_en, n_str, n_gap, n_halt, all_diff, sv;
    logic raw_v[3];
    int n_left;
    raw_v[0] = sw_debug;
    raw_v[1] = btn_step;
    raw_v[2] = btn_burst;
    if (rst) begin
      m_en = 0; m_str = 0; m_gap = 0; m_halt = 0; m_left = 0;
      m_steps = 16'h0 - pre_off;
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
        for (int j = 0; j < DB; j++) m_win[i][j] = 0;
      end
      mvalid = 1'b1;
    end else begin
      hit = bp_en && (pc == bp_addr);
      eff = m_lvl[0] | m_halt;
      n_en = m_en; n_str = m_str; n_gap = m_gap; n_halt = m_halt; n_left = m_left;
      if (!m_en) begin
        if (hit) begin n_halt = 1; n_en = 1; end
        else if (eff) n_en = 1;
      end else if (m_str) begin
        n_str = 0; n_gap = 1; m_steps = m_steps + 16'd1;
      end else if (m_gap) begin
        n_gap = 0;
        if (!eff) begin n_en = 0; n_left = 0; end
        else if (hit) begin n_halt = 1; n_left = 0; end
        else if (m_left > 0) begin n_left = m_left - 1; n_str = 1; end
      end else begin
        if (!eff) n_en = 0;
        else if (m_rise[1]) begin n_str = 1; n_left = 0; end
        else if (m_rise[2] && burst_len != 0) begin n_str = 1; n_left = int'(burst_len) - 1; end
      end
      if (m_fall[0]) n_halt = 0;
      m_en = n_en; m_str = n_str; m_gap = n_gap; m_halt = n_halt; m_left = n_left;
      for (int i = 0; i < 3; i++) begin
        sv = m_s2[i];
        for (int j = DB - 1; j > 0; j--) m_win[i][j] = m_win[i][j-1];
        m_win[i][0] = sv;
        all_diff = 1;
        for (int j = 0; j < DB; j++) if (m_win[i][j] == m_lvl[i]) all_diff = 0;
        m_rise[i] = 0;
        m_fall[i] = 0;
        if (all_diff) begin
          m_lvl[i]  = sv;
          m_rise[i] = sv;
          m_fall[i] = ~sv;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw_v[i];
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_debug_en", {31'b0, debug_en}, {31'b0, m_en});
      chk("model_debug_step", {31'b0, debug_step}, {31'b0, m_str});
      chk("model_halted", {31'b0, halted}, {31'b0, m_halt});
      chk("model_step_count", {16'b0, step_count}, {16'b0, 16'(m_steps + pre_off)});
    end
  end

  // Strobe monitor: rising edges and width of the last high run.
  int   n_strobes = 0;
  int   run = 0;
  int   last_run = 0;
  logic prev_step = 1'b0;
  always @(negedge clk) begin
    if (debug_step && !prev_step) n_strobes++;
    if (debug_step) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
    prev_step = debug_step;
  end

  initial begin
    int s0, s1, k;
    logic [15:0] c0;
    logic [11:0] pat;
    rst = 1; sw_debug = 0; btn_step = 0; btn_burst = 0; burst_len = 0;
    bp_en = 0; bp_addr = 0; pc = 0;
    tick(3);
    chk("rst_debug_en", {31'b0, debug_en}, 0);
    chk("rst_debug_step", {31'b0, debug_step}, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_step_count", {16'b0, step_count}, 0);
    rst = 0;
    tick(3);

    // 3-clock glitch never reaches debug_en
    sw_debug = 1; tick(3); sw_debug = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("glitch_en", {31'b0, debug_en}, 0);
    end
    // clean edge: debug_en rises 2+4+1 clocks later
    sw_debug = 1;
    tick(6); chk("en_lat6", {31'b0, debug_en}, 0);
    tick(1); chk("en_lat7", {31'b0, debug_en}, 1);

    // single step
    s0 = n_strobes;
    btn_step = 1; tick(8); btn_step = 0; tick(10);
    chk("single_strobes", n_strobes - s0, 1);
    chk("single_width", last_run, 1);
    chk("single_count", {16'b0, step_count}, 1);

    // step press landing inside a burst is dropped
    s0 = n_strobes; c0 = step_count; burst_len = 10;
    btn_burst = 1; tick(8); btn_burst = 0;
    btn_step = 1; tick(8); btn_step = 0; tick(30);
    chk("drop_strobes", n_strobes - s0, 10);
    chk("drop_count", {16'b0, 16'(step_count - c0)}, 10);

    // burst of 5: alternating pattern
    s0 = n_strobes; c0 = step_count; burst_len = 5;
    btn_burst = 1; tick(7);
    pat = {11'b0, debug_step};
    for (int i = 1; i < 12; i++) begin
      tick();
      if (i == 1) btn_burst = 0;
      pat = {pat[10:0], debug_step};
    end
    chk("burst5_pattern", {20'b0, pat}, 32'b1010_1010_1000);
    tick(6);
    chk("burst5_count", {16'b0, 16'(step_count - c0)}, 5);
    chk("burst5_idle_en", {31'b0, debug_en}, 1);

    // burst with breakpoint during 2nd STEP_LO
    s0 = n_strobes; bp_en = 1; bp_addr = 32'h10; pc = 0; burst_len = 5;
    btn_burst = 1; tick(7); tick(1); tick(1);
    chk("bp_2nd_hi", {31'b0, debug_step}, 1);
    pc = 32'h10; btn_burst = 0;
    tick(2);
    chk("bp_halted", {31'b0, halted}, 1);
    pc = 0; tick(8);
    chk("bp_strobes", n_strobes - s0, 2);

    // switch release clears halted and returns to free-run
    sw_debug = 0; tick(12);
    chk("clr_halted", {31'b0, halted}, 0);
    chk("clr_en", {31'b0, debug_en}, 0);

    // free-run breakpoint
    bp_addr = 32'h24; pc = 32'h20; tick(3);
    chk("fr_pre_en", {31'b0, debug_en}, 0);
    pc = 32'h24; tick(1);
    chk("fr_bp_en", {31'b0, debug_en}, 1);
    chk("fr_bp_halted", {31'b0, halted}, 1);
    pc = 32'h28; tick(3);
    sw_debug = 1; tick(12);
    chk("fr_sw_on_halted", {31'b0, halted}, 1);
    sw_debug = 0; tick(10);
    chk("fr_sw_off_halted", {31'b0, halted}, 0);
    chk("fr_sw_off_en", {31'b0, debug_en}, 0);
    bp_en = 0; pc = 0;

    // corners
    sw_debug = 1; tick(10);
    s0 = n_strobes; burst_len = 0;
    btn_burst = 1; tick(8); btn_burst = 0; tick(10);
    chk("zero_len", n_strobes - s0, 0);
    s0 = n_strobes; burst_len = 7;
    btn_step = 1; btn_burst = 1; tick(8); btn_step = 0; btn_burst = 0; tick(12);
    chk("coincident", n_strobes - s0, 1);
    s0 = n_strobes; burst_len = 200;
    btn_burst = 1; tick(8); btn_burst = 0; tick(12);
    sw_debug = 0; tick(30);
    chk("mid_release_en", {31'b0, debug_en}, 0);
    chk("mid_release_strobes", n_strobes - s0, 10);
    s1 = n_strobes; tick(20);
    chk("mid_release_stopped", n_strobes - s1, 0);

    // wrap of step_count
    sw_debug = 1; tick(10);
    force dut.step_cnt_q = 16'hFFFF;
    pre_off = 16'hFFFF - m_steps;
    #1 release dut.step_cnt_q;
    s0 = n_strobes;
    btn_step = 1; tick(8); btn_step = 0; tick(10);
    chk("wrap_count", {16'b0, step_count}, 0);
    chk("wrap_strobes", n_strobes - s0, 1);

    // reset during STEP_HI
    burst_len = 50;
    btn_burst = 1; tick(8); btn_burst = 0;
    k = 0;
    while (!debug_step && k < 10) begin tick(); k++; end
    if (!debug_step) begin
      checks++; errors++;
      $display("FAIL rst_wait: debug_step not seen within 10 clocks");
    end
    rst = 1; tick(1);
    chk("rst_mid_step", {31'b0, debug_step}, 0);
    chk("rst_mid_en", {31'b0, debug_en}, 0);
    chk("rst_mid_count", {16'b0, step_count}, 0);
    tick(2); rst = 0;
    s0 = n_strobes; tick(40);
    chk("rst_mid_no_more", n_strobes - s0, 0);

    // randomized phase checked by the model
    bp_addr = 32'h18;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 119) == 0) sw_debug = ~sw_debug;
      if (btn_step) begin if ($urandom_range(0, 4) == 0) btn_step = 0; end
      else if ($urandom_range(0, 11) == 0) btn_step = 1;
      if (btn_burst) begin if ($urandom_range(0, 4) == 0) btn_burst = 0; end
      else if ($urandom_range(0, 11) == 0) btn_burst = 1;
      if ($urandom_range(0, 19) == 0) burst_len = CW'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) bp_en = ~bp_en;
      pc = 32'h10 + 32'($urandom_range(0, 4)) * 4;
      rst = ($urandom_range(0, 2999) == 0);
      tick();
    end
    rst = 0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
